// File: rtl/lemon_mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction outstanding at a time.
// Optional: define ARB_ROUND_ROBIN_EN for round-robin arbitration (default: LSU has fixed priority).
module lemon_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rsp_data,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                busy,
  output logic                err
);

  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } state_e;

  state_e              state_q;
  logic                owner_lsu_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic                err_q;
  logic                grant_ifu;
  logic                grant_lsu;
  logic                idle;
  logic                rsp_fire;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_lsu_q;

  // On contention, grant whoever did not win last time.
  always_comb begin
    grant_ifu = ifu_req_valid;
    grant_lsu = lsu_req_valid;
    if (ifu_req_valid && lsu_req_valid) begin
      grant_ifu = last_lsu_q;
      grant_lsu = ~last_lsu_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_lsu_q <= 1'b1;
    end else if (state_q == S_IDLE && (grant_ifu || grant_lsu)) begin
      last_lsu_q <= grant_lsu;
    end
  end
`else
  assign grant_lsu = lsu_req_valid;
  assign grant_ifu = ifu_req_valid & ~lsu_req_valid;
`endif

  assign idle          = (state_q == S_IDLE) & ~rst;
  assign ifu_req_ready = idle & grant_ifu;
  assign lsu_req_ready = idle & grant_lsu;

  // Response pulse is combinational so it lands in the same cycle as mem_rsp_valid.
  assign rsp_fire      = (state_q == S_RSP) & mem_rsp_valid & ~rst;
  assign ifu_rsp_valid = rsp_fire & ~owner_lsu_q;
  assign lsu_rsp_valid = rsp_fire & owner_lsu_q;
  assign ifu_rsp_data  = ifu_rsp_valid ? mem_rsp_data : '0;
  assign lsu_rsp_data  = lsu_rsp_valid ? mem_rsp_data : '0;

  assign mem_req_valid = (state_q == S_REQ) & ~rst;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign busy          = (state_q != S_IDLE) & ~rst;
  assign err           = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_lsu_q <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      // A response outside RSP is a protocol violation; it is dropped and flagged.
      if (mem_rsp_valid && state_q != S_RSP) begin
        err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (grant_ifu || grant_lsu) begin
            owner_lsu_q <= grant_lsu;
            addr_q      <= grant_lsu ? lsu_addr : ifu_addr;
            wen_q       <= grant_lsu & lsu_wen;
            wdata_q     <= grant_lsu ? lsu_wdata : '0;
            wmask_q     <= grant_lsu ? lsu_wmask : '0;
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state_q <= S_RSP;
          end
        end
        S_RSP: begin
          if (mem_rsp_valid) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lemon_mem_arbiter.sv
// Self-checking bench for lemon_mem_arbiter: vector table, directed corner cases, random vs model.
module tb_lemon_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_addr, ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rsp_data;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
  logic [3:0]  mem_wmask;
  logic        busy, err;

  int n_chk  = 0;
  int n_fail = 0;

  lemon_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic        iv;
    logic        lv;
    logic [31:0] ia;
    logic [31:0] la;
    logic        lwen;
    logic [31:0] lwd;
    logic [3:0]  lwm;
    logic [31:0] rd;
    logic        exp_lsu;
  } vec_t;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b required %0b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
    chk1({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
    chk32({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk1({tag, "_mem_wen"}, mem_wen, 1'b0);
    chk32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk32({tag, "_mem_wmask"}, 32'(mem_wmask), 32'h0);
    chk1({tag, "_ifu_rsp_valid"}, ifu_rsp_valid, 1'b0);
    chk1({tag, "_lsu_rsp_valid"}, lsu_rsp_valid, 1'b0);
    chk32({tag, "_ifu_rsp_data"}, ifu_rsp_data, 32'h0);
    chk32({tag, "_lsu_rsp_data"}, lsu_rsp_data, 32'h0);
    chk1({tag, "_ifu_req_ready"}, ifu_req_ready, 1'b0);
    chk1({tag, "_lsu_req_ready"}, lsu_req_ready, 1'b0);
  endtask

  // Zero-wait transaction: accept, memory ready next cycle, response the cycle after.
  task automatic run_txn(input vec_t v, input string tag);
    ifu_req_valid = v.iv; ifu_addr = v.ia;
    lsu_req_valid = v.lv; lsu_addr = v.la; lsu_wen = v.lwen; lsu_wdata = v.lwd; lsu_wmask = v.lwm;
    mem_req_ready = 1'b0;
    @(negedge clk);
    chk1({tag, "_ifu_ready"}, ifu_req_ready, ~v.exp_lsu);
    chk1({tag, "_lsu_ready"}, lsu_req_ready, v.exp_lsu);
    chk1({tag, "_busy_idle"}, busy, 1'b0);
    step();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    chk1({tag, "_mem_req_valid"}, mem_req_valid, 1'b1);
    chk32({tag, "_mem_addr"}, mem_addr, v.exp_lsu ? v.la : v.ia);
    chk1({tag, "_mem_wen"}, mem_wen, v.exp_lsu & v.lwen);
    chk32({tag, "_mem_wdata"}, mem_wdata, v.exp_lsu ? v.lwd : 32'h0);
    chk32({tag, "_mem_wmask"}, 32'(mem_wmask), v.exp_lsu ? 32'(v.lwm) : 32'h0);
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = v.rd;
    @(negedge clk);
    chk1({tag, "_ifu_rsp_valid"}, ifu_rsp_valid, ~v.exp_lsu);
    chk1({tag, "_lsu_rsp_valid"}, lsu_rsp_valid, v.exp_lsu);
    chk32({tag, "_ifu_rsp_data"}, ifu_rsp_data, v.exp_lsu ? 32'h0 : v.rd);
    chk32({tag, "_lsu_rsp_data"}, lsu_rsp_data, v.exp_lsu ? v.rd : 32'h0);
    step();
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    @(negedge clk);
    chk1({tag, "_busy_after"}, busy, 1'b0);
    chk1({tag, "_no_pulse_after"}, ifu_rsp_valid | lsu_rsp_valid, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
  endtask

  // Reference model state for the random phase (transaction level).
  int          m_phase;      // 0 no transaction, 1 waiting for memory accept, 2 waiting for response
  logic        m_own_lsu;
  logic        m_last_lsu;
  logic [31:0] m_addr, m_wdata;
  logic        m_wen;
  logic [3:0]  m_wmask;

  initial begin
    vec_t vecs[5];
    logic exp_i, exp_l, acc_i, acc_l;
    int   txn_done;

    vecs[0] = '{iv:1'b1, lv:1'b0, ia:32'h8000_0000, la:32'h0, lwen:1'b0, lwd:32'h0, lwm:4'h0,
                rd:32'h0010_0073, exp_lsu:1'b0};
    vecs[1] = '{iv:1'b1, lv:1'b1, ia:32'h8000_0004, la:32'h8000_1000, lwen:1'b1, lwd:32'hDEAD_BEEF,
                lwm:4'hF, rd:32'h0, exp_lsu:1'b1};
    vecs[2] = '{iv:1'b1, lv:1'b0, ia:32'h8000_0004, la:32'h0, lwen:1'b0, lwd:32'h0, lwm:4'h0,
                rd:32'h1234_5678, exp_lsu:1'b0};
    vecs[3] = '{iv:1'b0, lv:1'b1, ia:32'h0, la:32'h8000_2000, lwen:1'b0, lwd:32'h5555_AAAA,
                lwm:4'h3, rd:32'hCAFE_F00D, exp_lsu:1'b1};
`ifdef ARB_ROUND_ROBIN_EN
    vecs[4] = '{iv:1'b1, lv:1'b1, ia:32'h0000_0020, la:32'h0000_0010, lwen:1'b0, lwd:32'h0,
                lwm:4'h0, rd:32'hA5A5_5A5A, exp_lsu:1'b0};
`else
    vecs[4] = '{iv:1'b1, lv:1'b1, ia:32'h0000_0020, la:32'h0000_0010, lwen:1'b0, lwd:32'h0,
                lwm:4'h0, rd:32'hA5A5_5A5A, exp_lsu:1'b1};
`endif

    do_reset();
    @(negedge clk);
    chk_all_zero("reset");

    for (int i = 0; i < 5; i++) begin
      step();
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Memory stalls 5 cycles in REQ: payload stable, no grants.
    step();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    @(negedge clk);
    chk1("stall_accept", ifu_req_ready, 1'b1);
    step();
    ifu_addr = 32'h1111_1111;
    lsu_req_valid = 1'b1; lsu_addr = 32'h2222_2222; lsu_wen = 1'b1; lsu_wdata = 32'h3333_3333;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk1("stall_mem_req_valid", mem_req_valid, 1'b1);
      chk32("stall_mem_addr", mem_addr, 32'h8000_0100);
      chk32("stall_mem_wdata", mem_wdata, 32'h0);
      chk1("stall_ifu_ready", ifu_req_ready, 1'b0);
      chk1("stall_lsu_ready", lsu_req_ready, 1'b0);
      step();
    end
    idle_inputs();
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk1("stall_release_valid", mem_req_valid, 1'b1);
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BAD_CAFE;
    @(negedge clk);
    chk1("stall_ifu_rsp", ifu_rsp_valid, 1'b1);
    chk32("stall_ifu_data", ifu_rsp_data, 32'h0BAD_CAFE);
    step();
    idle_inputs();

    // Response in the same cycle as memory accept: dropped, error raised, real response follows.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
    step();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h7777_7777;
    @(negedge clk);
    chk1("early_rsp_no_pulse", ifu_rsp_valid | lsu_rsp_valid, 1'b0);
    step();
    idle_inputs();
    @(negedge clk);
    chk1("early_rsp_err", err, 1'b1);
    chk1("early_rsp_busy", busy, 1'b1);
    step();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h8888_8888;
    @(negedge clk);
    chk1("early_rsp_late_pulse", ifu_rsp_valid, 1'b1);
    chk32("early_rsp_late_data", ifu_rsp_data, 32'h8888_8888);
    step();
    do_reset();

    // Stray response in IDLE: sticky error, no pulse, cleared by reset.
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_0000;
    @(negedge clk);
    chk1("idle_rsp_no_pulse", ifu_rsp_valid | lsu_rsp_valid, 1'b0);
    step();
    idle_inputs();
    @(negedge clk);
    chk1("idle_rsp_err", err, 1'b1);
    step(); step(); step();
    chk1("idle_rsp_err_sticky", err, 1'b1);
    do_reset();
    @(negedge clk);
    chk1("idle_rsp_err_cleared", err, 1'b0);

    // Reset while waiting for the response aborts the transaction.
    step();
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000;
    step();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h4444_4444;
    ifu_req_valid = 1'b1; ifu_addr = 32'h9999_0000;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_in_rsp");
    step();
    idle_inputs();
    rst = 1'b0;
    run_txn('{iv:1'b1, lv:1'b0, ia:32'h8000_0008, la:32'h0, lwen:1'b0, lwd:32'h0, lwm:4'h0,
              rd:32'h0000_0013, exp_lsu:1'b0}, "after_rst");

    // Both requesters held valid for six zero-wait transactions.
    do_reset();
    ifu_req_valid = 1'b1; ifu_addr = 32'h0000_1000;
    lsu_req_valid = 1'b1; lsu_addr = 32'h0000_2000; lsu_wen = 1'b1; lsu_wdata = 32'h1; lsu_wmask = 4'h1;
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_l = (k % 2) == 1;
`else
      exp_l = 1'b1;
`endif
      @(negedge clk);
      chk1($sformatf("order%0d_ifu_ready", k), ifu_req_ready, ~exp_l);
      chk1($sformatf("order%0d_lsu_ready", k), lsu_req_ready, exp_l);
      step();
      mem_req_ready = 1'b1;
      @(negedge clk);
      chk1($sformatf("order%0d_mem_wen", k), mem_wen, exp_l);
      chk32($sformatf("order%0d_mem_addr", k), mem_addr, exp_l ? 32'h0000_2000 : 32'h0000_1000);
      step();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'(k + 100);
      @(negedge clk);
      chk1($sformatf("order%0d_lsu_rsp", k), lsu_rsp_valid, exp_l);
      chk1($sformatf("order%0d_ifu_rsp", k), ifu_rsp_valid, ~exp_l);
      step();
      mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    end

    // Random traffic against the transaction-level model.
    do_reset();
    m_phase = 0; m_own_lsu = 1'b0; m_last_lsu = 1'b1;
    m_addr = '0; m_wdata = '0; m_wen = 1'b0; m_wmask = '0;
    acc_i = 1'b1; acc_l = 1'b1; txn_done = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (acc_i || $urandom_range(3) == 0) begin
        ifu_req_valid = 1'($urandom_range(1)); ifu_addr = $urandom;
      end
      if (acc_l || $urandom_range(3) == 0) begin
        lsu_req_valid = 1'($urandom_range(1)); lsu_addr = $urandom; lsu_wen = 1'($urandom_range(1));
        lsu_wdata = $urandom; lsu_wmask = 4'($urandom_range(15));
      end
      mem_req_ready = 1'($urandom_range(1));
      mem_rsp_valid = (m_phase == 2) && ($urandom_range(1) == 1);
      mem_rsp_data  = $urandom;
      @(negedge clk);
      exp_i = 1'b0; exp_l = 1'b0;
      if (m_phase == 0) begin
        if (ifu_req_valid && lsu_req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
          exp_l = ~m_last_lsu;
`else
          exp_l = 1'b1;
`endif
          exp_i = ~exp_l;
        end else begin
          exp_i = ifu_req_valid; exp_l = lsu_req_valid;
        end
      end
      chk1("rnd_ifu_ready", ifu_req_ready, exp_i);
      chk1("rnd_lsu_ready", lsu_req_ready, exp_l);
      chk1("rnd_busy", busy, m_phase != 0);
      chk1("rnd_mem_req_valid", mem_req_valid, m_phase == 1);
      if (m_phase == 1) begin
        chk32("rnd_mem_addr", mem_addr, m_addr);
        chk1("rnd_mem_wen", mem_wen, m_wen);
        chk32("rnd_mem_wdata", mem_wdata, m_wdata);
        chk32("rnd_mem_wmask", 32'(mem_wmask), 32'(m_wmask));
      end
      chk1("rnd_ifu_rsp_valid", ifu_rsp_valid, m_phase == 2 && mem_rsp_valid && !m_own_lsu);
      chk1("rnd_lsu_rsp_valid", lsu_rsp_valid, m_phase == 2 && mem_rsp_valid && m_own_lsu);
      chk32("rnd_ifu_rsp_data", ifu_rsp_data,
            (m_phase == 2 && mem_rsp_valid && !m_own_lsu) ? mem_rsp_data : 32'h0);
      chk32("rnd_lsu_rsp_data", lsu_rsp_data,
            (m_phase == 2 && mem_rsp_valid && m_own_lsu) ? mem_rsp_data : 32'h0);
      chk1("rnd_err", err, 1'b0);
      acc_i = exp_i; acc_l = exp_l;
      if (exp_i || exp_l) begin
        m_phase = 1; m_own_lsu = exp_l; m_last_lsu = exp_l;
        m_addr  = exp_l ? lsu_addr : ifu_addr;
        m_wen   = exp_l & lsu_wen;
        m_wdata = exp_l ? lsu_wdata : 32'h0;
        m_wmask = exp_l ? lsu_wmask : 4'h0;
      end else if (m_phase == 1 && mem_req_ready) begin
        m_phase = 2;
      end else if (m_phase == 2 && mem_rsp_valid) begin
        m_phase = 0; txn_done++;
      end
      step();
    end
    chk1("rnd_traffic_seen", txn_done > 50, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
